pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_pkg.sv | 13 +
 rtl/pc_seq_ctrl_redirect_counter.sv | 22 ++
 rtl/pc_seq_ctrl.sv | 103 ++++++++++
 tb/tb_pc_seq_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// Holds the sequencer state enum and the sequential PC step.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } pc_seq_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_seq_ctrl_redirect_counter.sv
// Saturating 16-bit counter of accepted redirects.
// Ports: clk, reset (sync, active-low), i_inc (count pulse), o_cnt (count).
module redirect_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: sequential step, stall, redirect+flush, halt.
// Ports: clk, reset (sync, active-low), pc_sel/br_pc (redirect), flag_halt,
//   stall; outputs cur_pc, flush_ifid, flush_idex, halted, misalign,
//   redirect_cnt (live only when PC_SEQ_STATS_EN is defined, else 0).
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int PC_W   = 9,
    parameter int RST_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_sel,
    input  logic [31:0]     br_pc,
    input  logic            flag_halt,
    input  logic            stall,
    output logic [PC_W-1:0] cur_pc,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            halted,
    output logic            misalign,
    output logic [15:0]     redirect_cnt
);

    localparam logic [PC_W-1:0] W_STEP  = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] W_RSTPC = PC_W'(RST_PC);

    pc_seq_state_t   r_state;
    pc_seq_state_t   w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_misalign;
    logic            w_mis_nxt;
    logic            w_accept;

    // Upper target bits lie outside the PC space and are dropped.
    logic w_unused;
    assign w_unused = &{1'b0, br_pc[31:PC_W]};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_mis_nxt   = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (flag_halt) begin
                    w_state_nxt = HALT;
                end else if (pc_sel) begin
                    w_accept    = 1'b1;
                    w_pc_nxt    = {br_pc[PC_W-1:2], 2'b00};
                    w_mis_nxt   = |br_pc[1:0];
                    w_state_nxt = FLUSH;
                end else if (!stall) begin
                    w_pc_nxt = r_pc + W_STEP;
                end
            end
            // Inputs here come from squashed instructions: ignore them.
            FLUSH: begin
                w_pc_nxt    = r_pc + W_STEP;
                w_state_nxt = RUN;
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= RUN;
            r_pc       <= W_RSTPC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= w_mis_nxt;
        end
    end

    assign cur_pc     = r_pc;
    assign flush_ifid = (r_state == FLUSH);
    assign flush_idex = (r_state == FLUSH);
    assign halted     = (r_state == HALT);
    assign misalign   = r_misalign;

`ifdef PC_SEQ_STATS_EN
    redirect_counter u_redirect_counter (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_accept),
        .o_cnt (redirect_cnt)
    );
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign redirect_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl.
// Drives inputs 1 time unit after each rising edge and checks outputs there.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_sel;
    logic [31:0] br_pc;
    logic        flag_halt;
    logic        stall;
    logic [8:0]  cur_pc;
    logic        flush_ifid;
    logic        flush_idex;
    logic        halted;
    logic        misalign;
    logic [15:0] redirect_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pc_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .pc_sel       (pc_sel),
        .br_pc        (br_pc),
        .flag_halt    (flag_halt),
        .stall        (stall),
        .cur_pc       (cur_pc),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .halted       (halted),
        .misalign     (misalign),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [8:0] pc,
                           input logic fl, input logic hl,
                           input logic ms);
        chk({tag, ".pc"}, 32'(cur_pc), 32'(pc));
        chk({tag, ".fifid"}, 32'(flush_ifid), 32'(fl));
        chk({tag, ".fidex"}, 32'(flush_idex), 32'(fl));
        chk({tag, ".halt"}, 32'(halted), 32'(hl));
        chk({tag, ".mis"}, 32'(misalign), 32'(ms));
    endtask

    function automatic logic [15:0] cnt_exp(input int n);
`ifdef PC_SEQ_STATS_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    initial begin
        reset     = 1'b0;
        pc_sel    = 1'b0;
        br_pc     = 32'h0;
        flag_halt = 1'b0;
        stall     = 1'b0;

        step();
        chk_all("rst", 9'h000, 1'b0, 1'b0, 1'b0);
        chk("rst.cnt", 32'(redirect_cnt), 32'(cnt_exp(0)));

        reset = 1'b1;
        step();
        chk_all("seq1", 9'h004, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("seq2", 9'h008, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("seq3", 9'h00C, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("seq4", 9'h010, 1'b0, 1'b0, 1'b0);

        pc_sel = 1'b1;
        br_pc  = 32'h0000_0040;
        step();
        chk_all("br1", 9'h040, 1'b1, 1'b0, 1'b0);
        chk("br1.cnt", 32'(redirect_cnt), 32'(cnt_exp(1)));

        br_pc = 32'h0000_0100;
        step();
        chk_all("flush_ign", 9'h044, 1'b0, 1'b0, 1'b0);
        chk("flush_ign.cnt", 32'(redirect_cnt), 32'(cnt_exp(1)));

        br_pc = 32'h0000_0086;
        step();
        chk_all("br2_mis", 9'h084, 1'b1, 1'b0, 1'b1);
        chk("br2.cnt", 32'(redirect_cnt), 32'(cnt_exp(2)));

        pc_sel = 1'b0;
        step();
        chk_all("after_mis", 9'h088, 1'b0, 1'b0, 1'b0);

        pc_sel = 1'b1;
        br_pc  = 32'h0000_01F8;
        step();
        chk_all("br3", 9'h1F8, 1'b1, 1'b0, 1'b0);
        pc_sel = 1'b0;
        step();
        chk_all("br3_fl", 9'h1FC, 1'b0, 1'b0, 1'b0);
        chk("br3.cnt", 32'(redirect_cnt), 32'(cnt_exp(3)));
        step();
        chk_all("wrap", 9'h000, 1'b0, 1'b0, 1'b0);

        stall = 1'b1;
        step();
        chk_all("stall1", 9'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("stall2", 9'h000, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("stall3", 9'h000, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        chk_all("unstall", 9'h004, 1'b0, 1'b0, 1'b0);

        flag_halt = 1'b1;
        pc_sel    = 1'b1;
        br_pc     = 32'h0000_0100;
        step();
        chk_all("halt", 9'h004, 1'b0, 1'b1, 1'b0);
        chk("halt.cnt", 32'(redirect_cnt), 32'(cnt_exp(3)));
        flag_halt = 1'b0;
        stall     = 1'b1;
        step();
        chk_all("halt_hold1", 9'h004, 1'b0, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        chk_all("halt_hold2", 9'h004, 1'b0, 1'b1, 1'b0);
        pc_sel = 1'b0;

        reset = 1'b0;
        step();
        chk_all("halt_rst", 9'h000, 1'b0, 1'b0, 1'b0);
        chk("halt_rst.cnt", 32'(redirect_cnt), 32'(cnt_exp(0)));
        reset = 1'b1;
        step();
        chk_all("post_rst", 9'h004, 1'b0, 1'b0, 1'b0);

        pc_sel = 1'b1;
        br_pc  = 32'h0000_0042;
        step();
        chk_all("br4", 9'h040, 1'b1, 1'b0, 1'b1);
        pc_sel = 1'b0;
        reset  = 1'b0;
        step();
        chk_all("fl_rst", 9'h000, 1'b0, 1'b0, 1'b0);
        chk("fl_rst.cnt", 32'(redirect_cnt), 32'(cnt_exp(0)));
        reset = 1'b1;
        step();
        chk_all("fl_rst_run", 9'h004, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
